// File: rtl/seq_div_4x2.sv
// Sequential restoring divider: one quotient bit per clock, START/BUSY/DONE handshake.
// Divide-by-zero short-circuits to FIN with DZ=1, Q=all ones, R=0.
module seq_div_4x2 #(
   parameter int WN = 4,
   parameter int WD = 2
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          START,
   input  logic [WN-1:0] N,
   input  logic [WD-1:0] D,
   output logic [WN-1:0] Q,
   output logic [WD-1:0] R,
   output logic          BUSY,
   output logic          DONE,
   output logic          DZ
);

   localparam int CW = $clog2(WN + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIN
   } state_t;

   state_t        state_q, state_d;
   logic [WN-1:0] sh_q, sh_d;
   logic [WD-1:0] dv_q, dv_d;
   logic [WD:0]   p_q, p_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [WN-1:0] q_q, q_d;
   logic [WD-1:0] r_q, r_d;
   logic          dz_q, dz_d;
   logic [WD+1:0] step;

   // Returns {quotient bit, restored partial remainder}. p_in[WD] is always 0,
   // so the WD+2-bit difference exposes the borrow in its MSB.
   function automatic logic [WD+1:0] restore_step(input logic [WD:0]   p_in,
                                                  input logic          msb,
                                                  input logic [WD-1:0] dv);
      logic [WD+1:0] t;
      t = {p_in, msb} - {2'b00, dv};
      if (t[WD+1])
         return {1'b0, p_in[WD-1:0], msb};
      else
         return {1'b1, t[WD:0]};
   endfunction

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      dv_d    = dv_q;
      p_d     = p_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      r_d     = r_q;
      dz_d    = dz_q;
      step    = restore_step(p_q, sh_q[WN-1], dv_q);

      case (state_q)
         S_IDLE: begin
            if (START) begin
               if (D != '0) begin
                  sh_d    = N;
                  dv_d    = D;
                  p_d     = '0;
                  cnt_d   = CW'(WN);
                  state_d = S_RUN;
               end else begin
                  q_d     = '1;
                  r_d     = '0;
                  dz_d    = 1'b1;
                  state_d = S_FIN;
               end
            end
         end
         S_RUN: begin
            p_d   = step[WD:0];
            sh_d  = {sh_q[WN-2:0], step[WD+1]};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               q_d     = {sh_q[WN-2:0], step[WD+1]};
               r_d     = step[WD-1:0];
               dz_d    = 1'b0;
               state_d = S_FIN;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         sh_q    <= '0;
         dv_q    <= '0;
         p_q     <= '0;
         cnt_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         dv_q    <= dv_d;
         p_q     <= p_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dz_q    <= dz_d;
      end
   end

   assign Q    = q_q;
   assign R    = r_q;
   assign DZ   = dz_q;
   assign BUSY = (state_q == S_RUN);
   assign DONE = (state_q == S_FIN);

endmodule

// File: tb/tb_seq_div_4x2.sv
// Scoreboard bench for seq_div_4x2: expected results are queued at issue time
// and a monitor compares them whenever DONE is presented.
module tb_seq_div_4x2;

   localparam int WN = 4;
   localparam int WD = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [WN-1:0] n;
   logic [WD-1:0] d;
   logic [WN-1:0] q;
   logic [WD-1:0] r;
   logic          busy;
   logic          done;
   logic          dz;

   typedef struct {
      int nv;
      int dv;
   } op_t;

   op_t sb[$];
   int  tests = 0;
   int  fails = 0;

   seq_div_4x2 #(.WN(WN), .WD(WD)) dut (
      .CLK  (clk),
      .RST  (rst),
      .START(start),
      .N    (n),
      .D    (d),
      .Q    (q),
      .R    (r),
      .BUSY (busy),
      .DONE (done),
      .DZ   (dz)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_op(input int nv, input int dv);
      op_t e;
      e.nv = nv;
      e.dv = dv;
      sb.push_back(e);
   endtask

   // Monitor: reference is plain integer division on the queued operands.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got DONE with Q=%0d R=%0d, expected no result", q, r);
         end else begin
            op_t e;
            int  eq, er, edz;
            e = sb.pop_front();
            if (e.dv == 0) begin
               eq = (1 << WN) - 1; er = 0; edz = 1;
            end else begin
               eq = e.nv / e.dv; er = e.nv % e.dv; edz = 0;
            end
            check($sformatf("q(%0d/%0d)", e.nv, e.dv), int'(q), eq);
            check($sformatf("r(%0d/%0d)", e.nv, e.dv), int'(r), er);
            check($sformatf("dz(%0d/%0d)", e.nv, e.dv), int'(dz), edz);
            if (e.dv != 0) begin
               check("invariant_n_eq_qd_plus_r", int'(q) * e.dv + int'(r), e.nv);
               check("invariant_r_lt_d", int'(int'(r) < e.dv), 1);
            end
         end
      end
   end

   // Issues one operation from IDLE and checks latency and BUSY duration.
   // With inject set, a second START (1/1) is pulsed mid-RUN and must be ignored.
   task automatic issue(input int nv, input int dv, input bit inject);
      int k;
      bit got;
      int busy_cnt;
      @(negedge clk);
      n = nv[WN-1:0];
      d = dv[WD-1:0];
      start = 1'b1;
      push_op(nv, dv);
      @(posedge clk);
      #1 start = 1'b0;
      got = 1'b0;
      busy_cnt = 0;
      for (k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (done) begin
            got = 1'b1;
            break;
         end
         if (inject && k == 2) begin
            start = 1'b1; n = 4'd1; d = 2'd1;
         end
         if (inject && k == 3) start = 1'b0;
      end
      check($sformatf("latency(%0d/%0d)", nv, dv), got ? k : -1, (dv == 0) ? 1 : WN + 1);
      check($sformatf("busy_cycles(%0d/%0d)", nv, dv), busy_cnt, (dv == 0) ? 0 : WN);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; n = '0; d = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_dz", int'(dz), 0);
      check("reset_q", int'(q), 0);
      check("reset_r", int'(r), 0);
      rst = 1'b0;

      issue(13, 3, 1'b0);
      issue(6, 2, 1'b0);
      issue(15, 1, 1'b0);
      issue(2, 3, 1'b0);
      issue(9, 0, 1'b0);
      issue(13, 3, 1'b1);
      issue(9, 0, 1'b0);

      // Reset sampled on the 2nd RUN edge of a 10/3 operation: nothing is delivered.
      @(negedge clk);
      n = 4'd10; d = 2'd3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrun_rst_busy", int'(busy), 0);
      check("midrun_rst_done", int'(done), 0);
      check("midrun_rst_dz", int'(dz), 0);
      check("midrun_rst_q", int'(q), 0);
      check("midrun_rst_r", int'(r), 0);
      rst = 1'b0;
      issue(10, 3, 1'b0);

      // Exhaustive sweep with START held high: operations must run back-to-back.
      @(negedge clk);
      n = '0; d = '0; start = 1'b1;
      push_op(0, 0);
      for (int i = 0; i < (1 << WN) * (1 << WD); i++) begin
         int  k;
         bit  got;
         int  cur_d;
         int  exp_k;
         got = 1'b0;
         cur_d = i % (1 << WD);
         exp_k = ((i == 0) ? 0 : 1) + ((cur_d == 0) ? 1 : WN + 1);
         for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin
               got = 1'b1;
               break;
            end
         end
         check($sformatf("b2b_gap(op %0d)", i), got ? k : -1, exp_k);
         if (i < (1 << WN) * (1 << WD) - 1) begin
            n = WN'((i + 1) / (1 << WD));
            d = WD'((i + 1) % (1 << WD));
            push_op((i + 1) / (1 << WD), (i + 1) % (1 << WD));
         end else begin
            start = 1'b0;
         end
      end

      repeat (30) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'b0);
      end

      repeat (4) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
